// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 5-bit accumulator CPU: decodes IR[2:0]
// and drives every datapath load enable, mux select, ALU op and memory strobe.
module cpu_control_fsm #(
    parameter int DBus = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [DBus-1:0] IR,
    output logic            MARL,
    output logic            SMMAR,
    output logic            IRL,
    output logic            PCL,
    output logic            SMPC,
    output logic            SMALUA,
    output logic            SMALUB,
    output logic            OPALU,
    output logic            AL,
    output logic            SMA,
    output logic            MCS,
    output logic            MRW,
    output logic            CLKMASK,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_D0,
        S_O1,
        S_E0,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_UND = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_e     state_q;
    state_e     state_d;
    logic [2:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[2:0];
    assign unused_ir = ^IR[DBus-1:3];
    assign halted    = CLKMASK;

    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend on IR as loaded at the end of F1, so they cannot be
    // registered; an async reset to IDLE still zeroes them immediately.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        MARL    = 1'b0;
        SMMAR   = 1'b0;
        IRL     = 1'b0;
        PCL     = 1'b0;
        SMPC    = 1'b0;
        SMALUA  = 1'b0;
        SMALUB  = 1'b0;
        OPALU   = 1'b0;
        AL      = 1'b0;
        SMA     = 1'b0;
        MCS     = 1'b0;
        MRW     = 1'b0;
        CLKMASK = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_F0;
            S_F0: begin
                MARL    = 1'b1;
                SMMAR   = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                MCS     = 1'b1;
                MRW     = 1'b1;
                IRL     = 1'b1;
                PCL     = 1'b1;
                SMPC    = 1'b1;
                state_d = S_D0;
            end
            S_D0: begin
                case (opcode)
                    OP_NOP, OP_UND: state_d = S_F0;
                    OP_HLT:         state_d = S_HALT;
                    default: begin
                        MARL    = 1'b1;
                        SMMAR   = 1'b1;
                        state_d = S_O1;
                    end
                endcase
            end
            S_O1: begin
                MCS     = 1'b1;
                MRW     = 1'b1;
                state_d = S_F0;
                case (opcode)
                    OP_LDI: begin
                        AL   = 1'b1;
                        PCL  = 1'b1;
                        SMPC = 1'b1;
                    end
                    OP_JMP: PCL = 1'b1;
                    OP_LDA, OP_ADD, OP_SUB: begin
                        MARL    = 1'b1;
                        PCL     = 1'b1;
                        SMPC    = 1'b1;
                        state_d = S_E0;
                    end
                    default: ;
                endcase
            end
            S_E0: begin
                MCS     = 1'b1;
                MRW     = 1'b1;
                AL      = 1'b1;
                state_d = S_F0;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    SMA    = 1'b1;
                    SMALUA = 1'b1;
                    SMALUB = 1'b1;
                    OPALU  = (opcode == OP_SUB);
                end
            end
            S_HALT: CLKMASK = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a behavioural datapath closes the loop around the
// controller and an instruction-level model predicts A, PC, halt and cycle counts.
module tb_cpu_control_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] IR;
    logic MARL, SMMAR, IRL, PCL, SMPC, SMALUA, SMALUB, OPALU, AL, SMA, MCS, MRW, CLKMASK, halted;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    // Datapath state and bench controls
    logic [4:0] mem [32];
    logic [4:0] pc_q, a_q, mar_q, ir_q;
    logic [4:0] data_mem, alu_a, alu_b, alu_out;
    logic       preload = 1'b1;
    logic       scramble_ir = 1'b0;
    logic [4:0] pre_pc = '0, pre_a = '0, pre_ir = '0;

    // Output vector order: MARL SMMAR IRL PCL SMPC SMALUA SMALUB OPALU AL SMA MCS MRW CLKMASK
    localparam logic [12:0] V_ZERO = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] V_F0   = 13'b1_1_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] V_F1   = 13'b0_0_1_1_1_0_0_0_0_0_1_1_0;
    localparam logic [12:0] V_EADD = 13'b0_0_0_0_0_1_1_0_1_1_1_1_0;
    localparam logic [12:0] V_HALT = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;

    cpu_control_fsm #(.DBus(5)) dut (
        .clock(clock), .reset(reset), .IR(IR),
        .MARL(MARL), .SMMAR(SMMAR), .IRL(IRL), .PCL(PCL), .SMPC(SMPC),
        .SMALUA(SMALUA), .SMALUB(SMALUB), .OPALU(OPALU), .AL(AL), .SMA(SMA),
        .MCS(MCS), .MRW(MRW), .CLKMASK(CLKMASK), .halted(halted)
    );

    always #5 clock = ~clock;

    assign IR       = ir_q;
    assign data_mem = mem[mar_q];
    assign alu_a    = SMALUA ? a_q : pc_q;
    assign alu_b    = SMALUB ? data_mem : 5'd1;
    assign alu_out  = OPALU ? alu_a - alu_b : alu_a + alu_b;

    always @(posedge clock) begin
        if (preload) begin
            pc_q  <= pre_pc;
            a_q   <= pre_a;
            ir_q  <= pre_ir;
            mar_q <= '0;
        end else if (scramble_ir) begin
            ir_q <= 5'($urandom);
        end else if (!CLKMASK) begin
            if (MARL) mar_q <= SMMAR ? pc_q : data_mem;
            if (IRL)  ir_q  <= data_mem;
            if (PCL)  pc_q  <= SMPC ? alu_out : data_mem;
            if (AL)   a_q   <= SMA ? alu_out : data_mem;
        end
    end

    always @(negedge clock) begin
        if ((MCS && !MRW) || (halted !== CLKMASK)) viol++;
    end

    function automatic logic [12:0] outs();
        return {MARL, SMMAR, IRL, PCL, SMPC, SMALUA, SMALUB, OPALU, AL, SMA, MCS, MRW, CLKMASK};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    // Holds reset for two edges while the datapath is preset, then releases;
    // returns #1 after the edge that enters F0 (cycle k=0).
    task automatic start(input logic [4:0] pc0, input logic [4:0] a0);
        #1 reset = 1'b0;
        preload = 1'b1;
        pre_pc  = pc0;
        pre_a   = a0;
        pre_ir  = 5'($urandom);
        repeat (2) @(posedge clock);
        #1 preload = 1'b0;
        reset = 1'b1;
        viol  = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Instruction-level model: executes up to max_instr instructions from pc/a.
    task automatic isa_run(input int max_instr, inout logic [4:0] pc, inout logic [4:0] a,
                           output int cyc, output bit hlt);
        logic [4:0] w, opnd;
        cyc = 0;
        hlt = 1'b0;
        for (int n = 0; n < max_instr && !hlt; n++) begin
            w  = mem[pc];
            pc = pc + 5'd1;
            case (w[2:0])
                3'd7: begin cyc += 3; hlt = 1'b1; end
                3'd4: begin cyc += 4; pc = mem[pc]; end
                3'd5: begin cyc += 4; a = mem[pc]; pc = pc + 5'd1; end
                3'd1, 3'd2, 3'd3: begin
                    cyc += 5;
                    opnd = mem[mem[pc]];
                    pc   = pc + 5'd1;
                    if (w[2:0] == 3'd1)      a = opnd;
                    else if (w[2:0] == 3'd2) a = a + opnd;
                    else                     a = a - opnd;
                end
                default: cyc += 3;
            endcase
        end
    endtask

    initial begin
        logic [4:0] epc, ea, a0;
        int         cyc;
        bit         hlt;

        // Reset held with random IR, then IDLE -> F0 -> F1
        clear_mem();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre_ir = 5'($urandom);
            @(posedge clock);
            #1 check("rst_outs", outs(), V_ZERO);
        end
        preload = 1'b0;
        reset   = 1'b1;
        #1 check("idle_outs", outs(), V_ZERO);
        run(1);
        check("f0_outs", outs(), V_F0);
        run(1);
        check("f1_outs", outs(), V_F1);

        // LDI 7; ADD 20; SUB 21; HLT
        clear_mem();
        mem[0] = 5'd5; mem[1] = 5'd7; mem[2] = 5'd2; mem[3] = 5'd20;
        mem[4] = 5'd3; mem[5] = 5'd21; mem[6] = 5'd7;
        mem[20] = 5'd5; mem[21] = 5'd3;
        start(5'd0, 5'd0);
        run(16);
        check("prog_not_halted_early", halted, 1'b0);
        run(1);
        check("prog_halted", halted, 1'b1);
        check("prog_a", a_q, 5'd9);
        check("prog_pc", pc_q, 5'd7);
        check("prog_rd_only", viol, 0);

        // Halt is sticky while IR changes
        scramble_ir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run(1);
            check("halt_sticky", outs(), V_HALT);
        end
        scramble_ir = 1'b0;
        check("halt_a_kept", a_q, 5'd9);
        reset = 1'b0;
        #1 check("halt_reset_outs", outs(), V_ZERO);
        @(posedge clock);
        #1 reset = 1'b1;
        run(1);
        check("halt_restart_f0", outs(), V_F0);

        // JMP 10 -> LDA 12 (M[12]=17)
        clear_mem();
        mem[0] = 5'd4; mem[1] = 5'd10; mem[10] = 5'd1; mem[11] = 5'd12; mem[12] = 5'd17;
        start(5'd0, 5'd0);
        run(5);
        check("jmp_fetch_mar", mar_q, 5'd10);
        run(4);
        check("jmp_a", a_q, 5'd17);
        check("jmp_pc", pc_q, 5'd12);

        // Undefined 110 then 11001 (reserved bits set, behaves as LDA)
        clear_mem();
        mem[0] = 5'd6; mem[1] = 5'd25; mem[2] = 5'd30; mem[30] = 5'd13;
        start(5'd0, 5'd4);
        run(2);
        check("und_d0_no_loads", outs(), V_ZERO);
        run(1);
        check("und_f0", outs(), V_F0);
        check("und_pc", pc_q, 5'd1);
        check("und_a", a_q, 5'd4);
        run(5);
        check("rsvd_lda_a", a_q, 5'd13);
        check("rsvd_lda_pc", pc_q, 5'd3);

        // Reset during E0 of ADD
        clear_mem();
        mem[0] = 5'd2; mem[1] = 5'd20; mem[20] = 5'd5;
        start(5'd0, 5'd3);
        run(4);
        check("e0_add_outs", outs(), V_EADD);
        #2 reset = 1'b0;
        #1 check("midrst_outs", outs(), V_ZERO);
        @(posedge clock);
        #1 check("midrst_a_kept", a_q, 5'd3);
        reset = 1'b1;
        #1 check("midrst_idle", outs(), V_ZERO);
        run(1);
        check("midrst_f0", outs(), V_F0);

        // Random programs against the instruction-level model
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = 5'($urandom);
            if (t % 3 == 0) mem[$urandom_range(0, 31)] = 5'd7;
            a0  = 5'($urandom);
            epc = 5'd0;
            ea  = a0;
            isa_run($urandom_range(1, 12), epc, ea, cyc, hlt);
            start(5'd0, a0);
            run(cyc);
            check("rnd_a", a_q, ea);
            check("rnd_pc", pc_q, epc);
            check("rnd_halted", halted, hlt);
            check("rnd_boundary", outs(), hlt ? V_HALT : V_F0);
            check("rnd_rd_only", viol, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
